// File: rtl/rom_load_ctrl_if.sv
// rom_load_ctrl_if: hps_io download stream in, core ROM write port out
interface rom_load_ctrl_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [24:0] rom_ad;
  logic [7:0]  rom_dt;
  logic        rom_en;
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  rom_ad, rom_dt, rom_en
  );
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output rom_ad, rom_dt, rom_en
  );
endinterface

// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: routes ioctl downloads to ROM/SYSMODE/DIP and owns the game core reset
module rom_load_ctrl #(
  parameter int HOLD_CYCLES   = 4800,
  parameter int MIN_ROM_BYTES = 65536
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  rom_load_ctrl_if.slave    io,
  input  logic              user_rst,
  output logic [7:0]        sysmode,
  output logic [63:0]       dsw,
  output logic              rom_valid,
  output logic              core_reset,
  output logic              led
);
  typedef enum logic [1:0] {NOROM, LOAD, HOLD, RUN} state_e;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  state_e      state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [25:0] cnt_q, cnt_d, addr1;
  logic [24:0] rom_ad_q, rom_ad_d;
  logic [7:0]  rom_dt_q, rom_dt_d, sysmode_q, sysmode_d;
  logic [63:0] dsw_q, dsw_d;
  logic        rom_en_q, rom_en_d, rom_valid_q, rom_valid_d;
  logic        core_reset_q, core_reset_d, led_q, led_d;
  logic        load_req, in_load, leave_load, enter0, rom_ok, wr0, wr1, wr_dip;
  assign load_req   = io.ioctl_download && (io.ioctl_index == 8'd0 || io.ioctl_index == 8'd1);
  assign in_load    = state_q == LOAD;
  assign leave_load = in_load && !io.ioctl_download;
  assign enter0     = load_req && !in_load && io.ioctl_index == 8'd0;
  assign rom_ok     = cnt_q >= 26'(MIN_ROM_BYTES);
  assign wr0        = in_load && io.ioctl_wr && io.ioctl_index == 8'd0;
  assign wr1        = in_load && io.ioctl_wr && io.ioctl_index == 8'd1 && io.ioctl_addr == '0;
  assign wr_dip     = io.ioctl_wr && io.ioctl_index == 8'd254 && io.ioctl_addr[24:3] == '0;
  assign addr1      = {1'b0, io.ioctl_addr} + 26'd1;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state_q <= NOROM;
    else          state_q <= state_d;
  // A download of index 0/1 wins over everything, including a pending user reset
  always_comb begin
    state_d = (load_req || (in_load && io.ioctl_download)) ? LOAD
            : leave_load ? (rom_ok ? HOLD : NOROM)
            : ((state_q == HOLD || state_q == RUN) && user_rst) ? HOLD
            : (state_q == HOLD && hold_q == '0) ? RUN
            : state_q;
  end
  always_comb begin
    hold_d       = (state_d == HOLD) ? ((state_q == HOLD && !user_rst) ? hold_q - 1'b1 : HW'(HOLD_CYCLES - 1)) : '0;
    cnt_d        = enter0 ? '0 : (wr0 && addr1 > cnt_q) ? addr1 : cnt_q;
    rom_valid_d  = enter0 ? 1'b0 : leave_load ? rom_ok : rom_valid_q;
    rom_en_d     = wr0;
    rom_ad_d     = wr0 ? io.ioctl_addr : rom_ad_q;
    rom_dt_d     = wr0 ? io.ioctl_dout : rom_dt_q;
    sysmode_d    = wr1 ? io.ioctl_dout : sysmode_q;
    dsw_d        = dsw_q;
    if (wr_dip) dsw_d[{io.ioctl_addr[2:0], 3'b000} +: 8] = io.ioctl_dout;
    core_reset_d = state_d != RUN;
    led_d        = state_d == LOAD;
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      hold_q       <= '0;
      cnt_q        <= '0;
      rom_valid_q  <= 1'b0;
      rom_en_q     <= 1'b0;
      rom_ad_q     <= '0;
      rom_dt_q     <= '0;
      sysmode_q    <= 8'h00;
      dsw_q        <= '1;
      core_reset_q <= 1'b1;
      led_q        <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      rom_valid_q  <= rom_valid_d;
      rom_en_q     <= rom_en_d;
      rom_ad_q     <= rom_ad_d;
      rom_dt_q     <= rom_dt_d;
      sysmode_q    <= sysmode_d;
      dsw_q        <= dsw_d;
      core_reset_q <= core_reset_d;
      led_q        <= led_d;
    end
  assign io.rom_en  = rom_en_q;
  assign io.rom_ad  = rom_ad_q;
  assign io.rom_dt  = rom_dt_q;
  assign sysmode    = sysmode_q;
  assign dsw        = dsw_q;
  assign rom_valid  = rom_valid_q;
  assign core_reset = core_reset_q;
  assign led        = led_q;
endmodule
